// File: rtl/gpu_isa_pkg.sv
// ISA definitions shared by the decoder: opcodes, datapath mux encodings
// and the packed per-instruction control word.
package gpu_isa_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_BRNZP = 4'd1,
    OP_CMP   = 4'd2,
    OP_ADD   = 4'd3,
    OP_SUB   = 4'd4,
    OP_MUL   = 4'd5,
    OP_DIV   = 4'd6,
    OP_LDR   = 4'd7,
    OP_STR   = 4'd8,
    OP_CONST = 4'd9,
    OP_RET   = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    RIM_ALU   = 2'd0,
    RIM_MEM   = 2'd1,
    RIM_CONST = 2'd2
  } reg_input_mux_e;

  typedef enum logic [1:0] {
    AAM_ADD = 2'd0,
    AAM_SUB = 2'd1,
    AAM_MUL = 2'd2,
    AAM_DIV = 2'd3
  } alu_arith_mux_e;

  typedef struct packed {
    logic           reg_write_en;
    logic           mem_read_en;
    logic           mem_write_en;
    logic           nzp_write_en;
    logic           alu_output_mux;
    logic           pc_mux;
    logic           ret;
    reg_input_mux_e reg_input_mux;
    alu_arith_mux_e alu_arith_mux;
  } ctrl_t;

endpackage

// File: rtl/decoder_ctrl_lut.sv
// Combinational opcode -> control word lookup; unknown opcodes flag illegal
// and yield an all-zero control word, identical to NOP.
module decoder_ctrl_lut
  import gpu_isa_pkg::*;
#(
  parameter int OPCODE_W = 4
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_t               ctrl,
  output logic                illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OPCODE_W'(OP_NOP):   ;
      OPCODE_W'(OP_BRNZP): ctrl.pc_mux = 1'b1;
      OPCODE_W'(OP_CMP): begin
        ctrl.nzp_write_en   = 1'b1;
        ctrl.alu_output_mux = 1'b1;
      end
      OPCODE_W'(OP_ADD): begin
        ctrl.reg_write_en  = 1'b1;
        ctrl.alu_arith_mux = AAM_ADD;
      end
      OPCODE_W'(OP_SUB): begin
        ctrl.reg_write_en  = 1'b1;
        ctrl.alu_arith_mux = AAM_SUB;
      end
      OPCODE_W'(OP_MUL): begin
        ctrl.reg_write_en  = 1'b1;
        ctrl.alu_arith_mux = AAM_MUL;
      end
      OPCODE_W'(OP_DIV): begin
        ctrl.reg_write_en  = 1'b1;
        ctrl.alu_arith_mux = AAM_DIV;
      end
      OPCODE_W'(OP_LDR): begin
        ctrl.reg_write_en  = 1'b1;
        ctrl.mem_read_en   = 1'b1;
        ctrl.reg_input_mux = RIM_MEM;
      end
      OPCODE_W'(OP_STR):   ctrl.mem_write_en = 1'b1;
      OPCODE_W'(OP_CONST): begin
        ctrl.reg_write_en  = 1'b1;
        ctrl.reg_input_mux = RIM_CONST;
      end
      OPCODE_W'(OP_RET):   ctrl.ret = 1'b1;
      default:             illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decoder_pipe.sv
// Instruction decoder with a 2-entry (output + skid) valid/ready buffer, 1-cycle latency.
// Optional sticky illegal-opcode trap enabled by defining DECODER_ILLEGAL_TRAP_EN.
module decoder_pipe
  import gpu_isa_pkg::*;
#(
  parameter int INSTR_W  = 16,
  parameter int OPCODE_W = 4,
  parameter int REG_AW   = 4,
  parameter int IMM_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [REG_AW-1:0]  rd_address,
  output logic [REG_AW-1:0]  rs_address,
  output logic [REG_AW-1:0]  rt_address,
  output logic [2:0]         nzp,
  output logic [IMM_W-1:0]   immediate,
  output logic               reg_write_en,
  output logic               mem_read_en,
  output logic               mem_write_en,
  output logic               nzp_write_en,
  output logic               alu_output_mux,
  output logic               pc_mux,
  output logic               ret,
  output logic [1:0]         reg_input_mux,
  output logic [1:0]         alu_arith_mux,
  output logic               illegal_err
);

  if (INSTR_W < OPCODE_W + 3*REG_AW || IMM_W > INSTR_W - OPCODE_W - REG_AW) begin : g_bad_params
    $error("decoder_pipe: instruction fields do not fit in INSTR_W");
  end

  localparam int RD_MSB = INSTR_W - OPCODE_W - 1;
  localparam int RS_MSB = RD_MSB - REG_AW;

  typedef struct packed {
    ctrl_t             ctrl;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic [2:0]        nzp;
    logic [IMM_W-1:0]  imm;
  } beat_t;

  ctrl_t in_ctrl;
  logic  in_illegal;
  beat_t in_beat;

  decoder_ctrl_lut #(.OPCODE_W(OPCODE_W)) u_lut (
    .opcode  (instruction[INSTR_W-1 -: OPCODE_W]),
    .ctrl    (in_ctrl),
    .illegal (in_illegal)
  );

  always_comb begin
    in_beat.ctrl = in_ctrl;
    in_beat.rd   = instruction[RD_MSB -: REG_AW];
    in_beat.rs   = instruction[RS_MSB -: REG_AW];
    in_beat.rt   = instruction[REG_AW-1:0];
    in_beat.nzp  = instruction[RD_MSB -: 3];
    in_beat.imm  = instruction[IMM_W-1:0];
  end

  logic  out_vld_q, out_vld_d;
  logic  skid_vld_q, skid_vld_d;
  logic  in_ready_q, in_ready_d;
  beat_t out_q, out_d;
  beat_t skid_q, skid_d;

  logic in_fire, out_fire;
  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_vld_q && out_ready;

  // Skid only fills while the output register is stalled, so when the output
  // frees up the skid entry always has priority over a new beat.
  always_comb begin
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    out_d      = out_q;
    skid_d     = skid_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!out_vld_q || out_fire) begin
      if (skid_vld_q) begin
        out_vld_d  = 1'b1;
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end else if (in_fire) begin
        out_vld_d = 1'b1;
        out_d     = in_beat;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_vld_d = 1'b1;
      skid_d     = in_beat;
    end
    in_ready_d = !skid_vld_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      in_ready_q <= 1'b0;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      in_ready_q <= in_ready_d;
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

`ifdef DECODER_ILLEGAL_TRAP_EN
  logic err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (in_fire && !flush && in_illegal) begin
      err_q <= 1'b1;
    end
  end
  assign illegal_err = err_q;
`else
  logic unused_illegal;
  assign unused_illegal = in_illegal;
  assign illegal_err    = 1'b0;
`endif

  assign in_ready       = in_ready_q;
  assign out_valid      = out_vld_q;
  assign rd_address     = out_q.rd;
  assign rs_address     = out_q.rs;
  assign rt_address     = out_q.rt;
  assign nzp            = out_q.nzp;
  assign immediate      = out_q.imm;
  assign reg_write_en   = out_q.ctrl.reg_write_en;
  assign mem_read_en    = out_q.ctrl.mem_read_en;
  assign mem_write_en   = out_q.ctrl.mem_write_en;
  assign nzp_write_en   = out_q.ctrl.nzp_write_en;
  assign alu_output_mux = out_q.ctrl.alu_output_mux;
  assign pc_mux         = out_q.ctrl.pc_mux;
  assign ret            = out_q.ctrl.ret;
  assign reg_input_mux  = out_q.ctrl.reg_input_mux;
  assign alu_arith_mux  = out_q.ctrl.alu_arith_mux;

endmodule

// File: tb/tb_decoder_pipe.sv
// Directed + random bench for decoder_pipe against a queue-based 2-deep FIFO model.
module tb_decoder_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] instruction = '0;

  logic       in_ready, out_valid;
  logic [3:0] rd_address, rs_address, rt_address;
  logic [2:0] nzp;
  logic [7:0] immediate;
  logic       reg_write_en, mem_read_en, mem_write_en, nzp_write_en;
  logic       alu_output_mux, pc_mux, ret, illegal_err;
  logic [1:0] reg_input_mux, alu_arith_mux;

  decoder_pipe dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .instruction(instruction),
    .out_valid(out_valid), .out_ready(out_ready),
    .rd_address(rd_address), .rs_address(rs_address), .rt_address(rt_address),
    .nzp(nzp), .immediate(immediate),
    .reg_write_en(reg_write_en), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
    .nzp_write_en(nzp_write_en), .alu_output_mux(alu_output_mux), .pc_mux(pc_mux),
    .ret(ret), .reg_input_mux(reg_input_mux), .alu_arith_mux(alu_arith_mux),
    .illegal_err(illegal_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [33:0] q[$];
  logic        model_rdy = 1'b0;
  logic        model_err = 1'b0;

  wire [33:0] obs = {rd_address, rs_address, rt_address, nzp, immediate,
                     reg_write_en, mem_read_en, mem_write_en, nzp_write_en,
                     alu_output_mux, pc_mux, ret, reg_input_mux, alu_arith_mux};

  // Expected decode straight from the ISA table.
  function automatic logic [33:0] ref_decode(input logic [15:0] w);
    int   op;
    logic regw, memr, memw, nzpw, aluo, pcm, rt_;
    logic [1:0] rim, aam;
    op = int'(w[15:12]);
    {regw, memr, memw, nzpw, aluo, pcm, rt_} = '0;
    rim = 2'd0;
    aam = 2'd0;
    if (op >= 3 && op <= 6) begin regw = 1; aam = 2'(op - 3); end
    else if (op == 7) begin regw = 1; memr = 1; rim = 2'd1; end
    else if (op == 9) begin regw = 1; rim = 2'd2; end
    else if (op == 8) memw = 1;
    else if (op == 2) begin nzpw = 1; aluo = 1; end
    else if (op == 1) pcm = 1;
    else if (op == 15) rt_ = 1;
    return {w[11:8], w[7:4], w[3:0], w[11:9], w[7:0],
            regw, memr, memw, nzpw, aluo, pcm, rt_, rim, aam};
  endfunction

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    logic        ifire, ofire;
    logic [15:0] w;
    ifire = in_valid && model_rdy && reset;
    ofire = (q.size() > 0) && out_ready;
    w     = instruction;
    @(posedge clk);
    if (!reset) begin
      q.delete();
      model_rdy = 1'b0;
      model_err = 1'b0;
    end else if (flush) begin
      q.delete();
      model_rdy = 1'b1;
    end else begin
      if (ofire) void'(q.pop_front());
      if (ifire) begin
        q.push_back(ref_decode(w));
`ifdef DECODER_ILLEGAL_TRAP_EN
        if (w[15:12] >= 4'd10 && w[15:12] <= 4'd14) model_err = 1'b1;
`endif
      end
      model_rdy = (q.size() < 2);
    end
    #1;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, model_rdy);
    chk("illegal_err", illegal_err, model_err);
    if (!reset) chk("reset_fields", obs, 0);
    else if (q.size() > 0) chk("fields", obs, q[0]);
  endtask

  initial begin
    // Reset state and release
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    chk("rdy_after_release", in_ready, 1);

    // ADD decode
    out_ready = 1'b1; in_valid = 1'b1; instruction = 16'h3123;
    cycle();
    in_valid = 1'b0;
    chk("add_valid", out_valid, 1);
    chk("add_rd", rd_address, 1);
    chk("add_rs", rs_address, 2);
    chk("add_rt", rt_address, 3);
    chk("add_regw", reg_write_en, 1);
    chk("add_muxes", {reg_input_mux, alu_arith_mux}, 0);
    cycle();

    // Backpressure: two beats buffered, third stalls
    out_ready = 1'b0; in_valid = 1'b1; instruction = 16'h9A55;
    cycle();
    instruction = 16'h7012;
    cycle();
    chk("skid_in_ready", in_ready, 0);
    instruction = 16'h3456;
    repeat (2) cycle();
    chk("bp_hold_imm", immediate, 8'h55);
    in_valid = 1'b0; out_ready = 1'b1;
    cycle();
    chk("bp_second_imm", immediate, 8'h12);
    chk("bp_rdy_back", in_ready, 1);
    cycle();
    chk("bp_drained", out_valid, 0);

    // Branch
    in_valid = 1'b1; instruction = 16'h1E00;
    cycle();
    in_valid = 1'b0;
    chk("br_pc_mux", pc_mux, 1);
    chk("br_nzp", nzp, 3'b111);
    chk("br_wen", {reg_write_en, mem_write_en, nzp_write_en}, 0);
    cycle();

    // Flush with two buffered beats and a third offered
    out_ready = 1'b0; in_valid = 1'b1; instruction = 16'h3111;
    cycle();
    instruction = 16'h4222;
    cycle();
    flush = 1'b1; instruction = 16'h5333;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", out_valid, 0);
    chk("flush_rdy", in_ready, 1);
    out_ready = 1'b1;
    cycle();
    chk("flush_no_output", out_valid, 0);

    // Illegal opcode
    in_valid = 1'b1; instruction = 16'hA000;
    cycle();
    in_valid = 1'b0;
    chk("illegal_ctrl", obs, 0);
`ifdef DECODER_ILLEGAL_TRAP_EN
    chk("illegal_set", illegal_err, 1);
`else
    chk("illegal_off", illegal_err, 0);
`endif
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    cycle();

    // Async reset with both entries full
    out_ready = 1'b0; in_valid = 1'b1; instruction = 16'h5ABC;
    cycle();
    instruction = 16'h8DEF;
    cycle();
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_async_valid", out_valid, 0);
    chk("rst_async_rdy", in_ready, 0);
    chk("rst_async_fields", obs, 0);
    chk("rst_async_err", illegal_err, 0);
    q.delete(); model_rdy = 1'b0; model_err = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    chk("rst_rdy_return", in_ready, 1);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      instruction = 16'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 19) == 0);
      cycle();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cycle();
    chk("final_empty", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
